// File: rtl/bmult_pkg.sv
// Shared constants and result record for the multiplier issue controller.
// Defining BMULT_ISSUE_TAG_EN adds an 8-bit tag field to the result record.
package bmult_pkg;
  localparam int BMULT_W           = 30;
  localparam int BMULT_LAT_DEFAULT = 2;
  localparam int BMULT_TAG_W       = 8;

  typedef struct packed {
    logic [2*BMULT_W-1:0] product;
`ifdef BMULT_ISSUE_TAG_EN
    logic [BMULT_TAG_W-1:0] tag;
`endif
  } bmult_res_t;
endpackage

// File: rtl/bmult_result_fifo.sv
// Show-ahead result FIFO: the head entry is visible on pop_data whenever empty is low.
module bmult_result_fifo
  import bmult_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = $bits(bmult_res_t),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [DW-1:0]    pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign count    = count_q;
endmodule

// File: rtl/bmult_issue_ctrl.sv
// Credit-based issue controller for a pipelined multiplier with an in-order result FIFO.
// Defining BMULT_ISSUE_TAG_EN adds in_tag/out_tag carried alongside each product.
module bmult_issue_ctrl
  import bmult_pkg::*;
#(
  parameter int W        = BMULT_W,
  parameter int MULT_LAT = BMULT_LAT_DEFAULT,
  parameter int DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
`ifdef BMULT_ISSUE_TAG_EN
  input  logic [BMULT_TAG_W-1:0] in_tag,
  output logic [BMULT_TAG_W-1:0] out_tag,
`endif
  output logic           busy
);
  localparam int CNT_W  = $clog2(2*DEPTH + 1);
  localparam int FCNT_W = $clog2(DEPTH + 1);
`ifdef BMULT_ISSUE_TAG_EN
  localparam int RES_W  = 2*W + BMULT_TAG_W;
`else
  localparam int RES_W  = 2*W;
`endif

  logic              accept, capture, pop, fifo_empty;
  logic              vld_q [MULT_LAT+1];
  logic              vld_d [MULT_LAT+1];
  logic [W-1:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d, credit_used;
  logic [FCNT_W-1:0] fifo_cnt;
  logic [RES_W-1:0]  push_data, head_data;

  // Credits come only from registered counters, so a pop frees a slot one cycle later.
  always_comb begin
    credit_used = inflight_q + CNT_W'(fifo_cnt);
    in_ready    = rst_n && (credit_used < CNT_W'(DEPTH));
    accept      = in_valid && in_ready;
    capture     = vld_q[MULT_LAT];
    out_valid   = rst_n && !fifo_empty;
    pop         = out_valid && out_ready;
    busy        = rst_n && ((inflight_q != '0) || !fifo_empty);
    mul_a_d     = accept ? in_a : mul_a_q;
    mul_b_d     = accept ? in_b : mul_b_q;
    inflight_d  = inflight_q;
    case ({accept, capture})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      inflight_q <= '0;
    end else begin
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb vld_d[0] = accept;

  genvar gi;
  generate
    for (gi = 1; gi <= MULT_LAT; gi++) begin : g_vld_shift
      always_comb vld_d[gi] = vld_q[gi-1];
    end
    for (gi = 0; gi <= MULT_LAT; gi++) begin : g_vld_reg
      always_ff @(posedge clk) begin
        if (!rst_n) vld_q[gi] <= 1'b0;
        else        vld_q[gi] <= vld_d[gi];
      end
    end
  endgenerate

`ifdef BMULT_ISSUE_TAG_EN
  // Tags shift every cycle in lockstep with the valid bits.
  logic [BMULT_TAG_W-1:0] tag_q [MULT_LAT+1];
  logic [BMULT_TAG_W-1:0] tag_d [MULT_LAT+1];

  always_comb tag_d[0] = in_tag;

  generate
    for (gi = 1; gi <= MULT_LAT; gi++) begin : g_tag_shift
      always_comb tag_d[gi] = tag_q[gi-1];
    end
    for (gi = 0; gi <= MULT_LAT; gi++) begin : g_tag_reg
      always_ff @(posedge clk) begin
        if (!rst_n) tag_q[gi] <= '0;
        else        tag_q[gi] <= tag_d[gi];
      end
    end
  endgenerate

  assign push_data        = {mul_p, tag_q[MULT_LAT]};
  assign {out_p, out_tag} = head_data;
`else
  assign push_data = mul_p;
  assign out_p     = head_data;
`endif

  bmult_result_fifo #(
    .DEPTH (DEPTH),
    .DW    (RES_W),
    .CNT_W (FCNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head_data),
    .count     (fifo_cnt),
    .empty     (fifo_empty)
  );

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
endmodule

// File: tb/tb_bmult_issue_ctrl.sv
// Directed self-checking bench for bmult_issue_ctrl with a MULT_LAT-stage multiplier model.
module tb_bmult_issue_ctrl;
  localparam int W     = 30;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]   in_a, in_b, mul_a, mul_b;
  logic [2*W-1:0] mul_p, out_p;
`ifdef BMULT_ISSUE_TAG_EN
  logic [7:0]     in_tag, out_tag;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bmult_issue_ctrl #(.W(W), .MULT_LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
`ifdef BMULT_ISSUE_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .busy      (busy)
  );

  // External multiplier: LAT registers between OPA/OPB and P.
  logic [2*W-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_p = mpipe[LAT-1];

  // Under credit flow control a capture must never meet a full FIFO.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      assert (!(dut.capture && (dut.fifo_cnt == DEPTH) && !dut.pop)) else begin
        errors++;
        $error("FAIL capture_into_full: observed capture with fifo_cnt=%0d required no capture", dut.fifo_cnt);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] op_a [32];
  logic [W-1:0] op_b [32];
  logic [7:0]   op_tag [32];
  int n_ops, sent, got;

  // One cycle of handshaking: offer next op, consume and check any result popped at this edge.
  task automatic step(input string tag);
    logic acc, pp;
    in_valid = (sent < n_ops);
    in_a     = op_a[sent % 32];
    in_b     = op_b[sent % 32];
`ifdef BMULT_ISSUE_TAG_EN
    in_tag   = op_tag[sent % 32];
`endif
    #0;
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    if (pp) begin
      check(tag, {4'b0, out_p}, {34'b0, op_a[got % 32]} * {34'b0, op_b[got % 32]});
`ifdef BMULT_ISSUE_TAG_EN
      check({tag, "_tag"}, {56'b0, out_tag}, {56'b0, op_tag[got % 32]});
`endif
      $display("%s result %0d: out_p=%h", tag, got, out_p);
      got++;
    end
    tick();
    if (acc) sent++;
    in_valid = 1'b0;
  endtask

  int n, vcnt;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
`ifdef BMULT_ISSUE_TAG_EN
    in_tag = '0;
`endif
    repeat (3) tick();
    check("rst_in_ready",  {63'b0, in_ready},  64'd0);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_busy",      {63'b0, busy},      64'd0);
    check("rst_mul_a",     {34'b0, mul_a},     64'd0);
    rst_n = 1'b1;
    #0;
    check("post_rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Single op 3*5, latency counted from the accepting edge.
    in_a = 30'd3; in_b = 30'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_mul_a", {34'b0, mul_a}, 64'd3);
    check("single_busy",  {63'b0, busy},  64'd1);
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    check("single_latency", 64'(n), 64'd3);
    check("single_out_p", {4'b0, out_p}, 64'd15);
    $display("single result: out_p=%0d after %0d cycles", out_p, n);
    tick();
    check("single_drained_valid", {63'b0, out_valid}, 64'd0);
    check("single_drained_busy",  {63'b0, busy},      64'd0);

    // Largest operands.
    in_a = 30'h3FFF_FFFF; in_b = 30'h3FFF_FFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    check("max_latency", 64'(n), 64'd3);
    check("max_out_p", {4'b0, out_p}, 64'h0FFF_FFFF_8000_0001);
    $display("max result: out_p=%h", out_p);
    tick();

    // Backpressure: six ops offered, only DEPTH credits.
    for (int i = 0; i < 6; i++) begin
      op_a[i] = 30'(i + 1); op_b[i] = 30'(i + 10); op_tag[i] = 8'(i);
    end
    n_ops = 6; sent = 0; got = 0; out_ready = 1'b0;
    repeat (10) step("bp");
    check("bp_accepted",  64'(sent), 64'd4);
    check("bp_in_ready",  {63'b0, in_ready},  64'd0);
    check("bp_head_valid", {63'b0, out_valid}, 64'd1);
    check("bp_head_p",    {4'b0, out_p}, 64'd10);
    out_ready = 1'b1;
    #0;
    check("bp_ready_lag", {63'b0, in_ready}, 64'd0);
    n = 0;
    while (got < 6 && n < 40) begin step("bp"); n++; end
    check("bp_got",  64'(got),  64'd6);
    check("bp_sent", 64'(sent), 64'd6);

    // Streaming 20 ops with a ready consumer.
    for (int i = 0; i < 20; i++) begin
      op_a[i] = 30'h3FFF_FFFF - 30'(i * 12345);
      op_b[i] = 30'(i * 98765 + 1);
      op_tag[i] = 8'(8'h40 + i);
    end
    n_ops = 20; sent = 0; got = 0;
    n = 0;
    while (got < 20 && n < 60) begin step("stream"); n++; end
    check("stream_got",  64'(got),  64'd20);
    check("stream_idle", {63'b0, busy}, 64'd0);

    // Reset with two ops in flight.
    in_a = 30'd2; in_b = 30'd3; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0; rst_n = 1'b0;
    #0;
    check("midrst_in_ready",  {63'b0, in_ready},  64'd0);
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_busy",      {63'b0, busy},      64'd0);
    tick();
    rst_n = 1'b1;
    #0;
    check("midrst_mul_a",    {34'b0, mul_a}, 64'd0);
    check("midrst_busy_after", {63'b0, busy}, 64'd0);
    vcnt = 0;
    repeat (8) begin tick(); if (out_valid) vcnt++; end
    check("midrst_no_results", 64'(vcnt), 64'd0);

`ifdef BMULT_ISSUE_TAG_EN
    op_a[0] = 30'd7;  op_b[0] = 30'd9;  op_tag[0] = 8'hA5;
    op_a[1] = 30'd11; op_b[1] = 30'd13; op_tag[1] = 8'h3C;
    n_ops = 2; sent = 0; got = 0; n = 0;
    while (got < 2 && n < 20) begin step("tag"); n++; end
    check("tag_got", 64'(got), 64'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
